// File: rtl/gpu_rect_scan_if.sv
// Bus bundle for the rectangle scan controller: command, status,
// row-base LUT handshake and the pixel address stream.
`timescale 1ns/1ps

interface gpu_rect_scan_if #(
    parameter int WIDTH_BITS  = 9,
    parameter int HEIGHT_BITS = 8,
    parameter int SUM_BITS    = 17
) ();

    // Command from the GPU command decoder
    logic                   start;
    logic [WIDTH_BITS-1:0]  x0;
    logic [WIDTH_BITS-1:0]  x1;
    logic [HEIGHT_BITS-1:0] y0;
    logic [HEIGHT_BITS-1:0] y1;
    logic                   abort;

    // Status
    logic                   busy;
    logic                   done;

    // Row-base lookup table (combinational table lives outside)
    logic [HEIGHT_BITS-1:0] lut_y;
    logic [SUM_BITS-1:0]    lut_base;

    // Pixel address stream toward the framebuffer write/fill engine
    logic                   out_valid;
    logic                   out_ready;
    logic [SUM_BITS-1:0]    out_addr;
    logic [WIDTH_BITS-1:0]  out_x;
    logic [HEIGHT_BITS-1:0] out_y;
    logic                   out_last;

    // The scan controller drives the stream and the LUT row index
    modport master (
        input  start, x0, x1, y0, y1, abort,
        output busy, done,
        output lut_y,
        input  lut_base,
        output out_valid, out_addr, out_x, out_y, out_last,
        input  out_ready
    );

    // Environment side: command source, LUT and stream consumer
    modport slave (
        output start, x0, x1, y0, y1, abort,
        input  busy, done,
        input  lut_y,
        output lut_base,
        input  out_valid, out_addr, out_x, out_y, out_last,
        output out_ready
    );

endinterface

// File: rtl/gpu_rect_scan.sv
// Rectangle scan controller. Walks every pixel of an inclusive rectangle
// in row-major order and emits one linear framebuffer address per pixel.
// The row base (y*WIDTH) comes from an external combinational LUT that is
// indexed by the current row, so the address is simply base + column.
`timescale 1ns/1ps

module gpu_rect_scan #(
    parameter int WIDTH       = 320,
    parameter int HEIGHT      = 240,
    parameter int WIDTH_BITS  = 9,
    parameter int HEIGHT_BITS = 8,
    parameter int SUM_BITS    = 17
) (
    input  logic            clk,
    input  logic            rst,
    gpu_rect_scan_if.master bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Largest legal coordinates; corners beyond the screen are pulled in
    localparam logic [WIDTH_BITS-1:0]  X_MAX = WIDTH_BITS'(WIDTH - 1);
    localparam logic [HEIGHT_BITS-1:0] Y_MAX = HEIGHT_BITS'(HEIGHT - 1);

    logic [1:0]             state;
    logic [1:0]             state_next;

    // Captured rectangle bounds (ordered and clamped)
    logic [WIDTH_BITS-1:0]  xl;
    logic [WIDTH_BITS-1:0]  xr;
    logic [HEIGHT_BITS-1:0] yt;
    logic [HEIGHT_BITS-1:0] yb;

    // Current scan position
    logic [WIDTH_BITS-1:0]  cur_x;
    logic [HEIGHT_BITS-1:0] cur_y;

    // Bounds derived from the command inputs in the start cycle
    logic [WIDTH_BITS-1:0]  x_lo;
    logic [WIDTH_BITS-1:0]  x_hi;
    logic [HEIGHT_BITS-1:0] y_lo;
    logic [HEIGHT_BITS-1:0] y_hi;
    logic [WIDTH_BITS-1:0]  cmd_xl;
    logic [WIDTH_BITS-1:0]  cmd_xr;
    logic [HEIGHT_BITS-1:0] cmd_yt;
    logic [HEIGHT_BITS-1:0] cmd_yb;

    logic                   in_idle;
    logic                   in_run;
    logic                   accept_cmd;
    logic                   handshake;
    logic                   at_row_end;
    logic                   at_last;

    assign in_idle    = (state == ST_IDLE);
    assign in_run     = (state == ST_RUN);
    assign accept_cmd = in_idle && bus.start;
    assign handshake  = in_run && bus.out_ready;
    assign at_row_end = (cur_x == xr);
    assign at_last    = at_row_end && (cur_y == yb);

    // Order the corners first, then clamp, so a rectangle that straddles
    // the screen edge keeps its on-screen part rather than collapsing.
    always_comb begin
        x_lo   = (bus.x0 < bus.x1) ? bus.x0 : bus.x1;
        x_hi   = (bus.x0 < bus.x1) ? bus.x1 : bus.x0;
        y_lo   = (bus.y0 < bus.y1) ? bus.y0 : bus.y1;
        y_hi   = (bus.y0 < bus.y1) ? bus.y1 : bus.y0;
        cmd_xl = (x_lo > X_MAX) ? X_MAX : x_lo;
        cmd_xr = (x_hi > X_MAX) ? X_MAX : x_hi;
        cmd_yt = (y_lo > Y_MAX) ? Y_MAX : y_lo;
        cmd_yb = (y_hi > Y_MAX) ? Y_MAX : y_hi;
    end

    // Next-state logic: abort beats completion so an aborted scan never
    // pulses done, even if its final pixel is accepted in the abort cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else if (handshake && at_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the rectangle bounds when a command is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xl <= '0;
            xr <= '0;
            yt <= '0;
            yb <= '0;
        end else if (accept_cmd) begin
            xl <= cmd_xl;
            xr <= cmd_xr;
            yt <= cmd_yt;
            yb <= cmd_yb;
        end
    end

    // Advance the scan position on each accepted pixel; the final pixel
    // leaves the position parked so the address stays defined until IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_x <= '0;
            cur_y <= '0;
        end else if (accept_cmd) begin
            cur_x <= cmd_xl;
            cur_y <= cmd_yt;
        end else if (handshake && !at_last) begin
            if (!at_row_end) begin
                cur_x <= cur_x + WIDTH_BITS'(1);
            end else begin
                cur_x <= xl;
                cur_y <= cur_y + HEIGHT_BITS'(1);
            end
        end
    end

    // Outputs are decoded from registers only; the address path runs
    // through the external LUT and one adder within the same cycle.
    always_comb begin
        bus.busy      = !in_idle;
        bus.done      = (state == ST_DONE);
        bus.out_valid = in_run;
        bus.out_last  = at_last && in_run;
        bus.out_x     = cur_x;
        bus.out_y     = cur_y;
        bus.lut_y     = cur_y;
        bus.out_addr  = bus.lut_base + SUM_BITS'(cur_x);
    end

endmodule

// File: tb/tb_gpu_rect_scan.sv
// Self-checking bench for gpu_rect_scan: a rectangle reference model fills
// a scoreboard queue on each command; a monitor pops it on every accepted
// pixel and also tracks the done pulse.
`timescale 1ns/1ps

module tb_gpu_rect_scan;

    localparam int FB_W = 320;
    localparam int FB_H = 240;

    typedef struct packed {
        logic [16:0] addr;
        logic [8:0]  x;
        logic [7:0]  y;
        logic        last;
    } beat_t;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;
    int accepted;
    int done_count;
    bit pending_done;
    beat_t exp_q[$];
    beat_t mon_e;

    gpu_rect_scan_if #(.WIDTH_BITS(9), .HEIGHT_BITS(8), .SUM_BITS(17)) bus ();

    gpu_rect_scan #(
        .WIDTH(320), .HEIGHT(240), .WIDTH_BITS(9), .HEIGHT_BITS(8), .SUM_BITS(17)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Row-base table: base of row y in a 320-wide framebuffer
    assign bus.lut_base = 17'(bus.lut_y) * 17'd320;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: every pixel of the ordered, clamped rectangle in
    // row-major order, address = y*320 + x
    task automatic pushModel(input int ax0, input int ax1, input int ay0, input int ay1,
                             output int npix);
        int xl, xr, yt, yb;
        beat_t b;
        xl = (ax0 < ax1) ? ax0 : ax1;
        xr = (ax0 < ax1) ? ax1 : ax0;
        yt = (ay0 < ay1) ? ay0 : ay1;
        yb = (ay0 < ay1) ? ay1 : ay0;
        if (xl > FB_W - 1) xl = FB_W - 1;
        if (xr > FB_W - 1) xr = FB_W - 1;
        if (yt > FB_H - 1) yt = FB_H - 1;
        if (yb > FB_H - 1) yb = FB_H - 1;
        npix = 0;
        for (int y = yt; y <= yb; y++) begin
            for (int x = xl; x <= xr; x++) begin
                b.addr = 17'(y * FB_W + x);
                b.x    = 9'(x);
                b.y    = 8'(y);
                b.last = (x == xr) && (y == yb);
                exp_q.push_back(b);
                npix++;
            end
        end
    endtask

    task automatic waitIdle();
        int cyc;
        cyc = 0;
        while (bus.busy && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (bus.busy) checkOutput("idle_timeout", bus.busy, 0);
    endtask

    // Issue one command and drive the stream until the block is idle again.
    // ready_pct < 0: ready low for the first three RUN cycles, then high.
    // abort_after = -1: no abort; -2: abort after a random handshake count.
    task automatic applyStimulus(input int ax0, input int ax1, input int ay0, input int ay1,
                                 input int abort_after_in, input int ready_pct,
                                 input bit restart_mid);
        int npix, acc0, done0, run_cycles, abort_after, cyc;
        bit aborted;
        waitIdle();
        pushModel(ax0, ax1, ay0, ay1, npix);
        abort_after = abort_after_in;
        if (abort_after == -2) abort_after = int'($urandom_range(npix - 1));
        if (abort_after >= npix) abort_after = -1;
        acc0  = accepted;
        done0 = done_count;
        bus.start = 1'b1;
        bus.x0 = 9'(ax0); bus.x1 = 9'(ax1);
        bus.y0 = 8'(ay0); bus.y1 = 8'(ay1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        checkOutput("start_latency_valid", bus.out_valid, 1);
        checkOutput("start_latency_busy", bus.busy, 1);
        run_cycles = 0;
        aborted = 1'b0;
        for (cyc = 0; cyc < 5000; cyc++) begin
            if (!bus.busy) break;
            if (bus.out_valid) run_cycles++;
            if (ready_pct < 0) begin
                bus.out_ready = (cyc >= 3);
                if (cyc < 3) checkOutput("bp_valid_held", bus.out_valid, 1);
            end else begin
                bus.out_ready = (int'($urandom_range(99)) < ready_pct);
            end
            bus.start = restart_mid && (cyc == 2);
            bus.x0 = 9'($urandom); bus.x1 = 9'($urandom);
            bus.y0 = 8'($urandom); bus.y1 = 8'($urandom);
            bus.abort = (abort_after >= 0) && ((accepted - acc0) >= abort_after);
            @(posedge clk); #1;
            if (bus.abort) begin
                bus.abort = 1'b0;
                aborted = 1'b1;
                checkOutput("abort_busy", bus.busy, 0);
                checkOutput("abort_valid", bus.out_valid, 0);
                checkOutput("abort_done", bus.done, 0);
                break;
            end
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        if (bus.busy) checkOutput("scan_timeout", bus.busy, 0);
        if (aborted) begin
            checkOutput("abort_remaining", exp_q.size(), npix - (accepted - acc0));
            checkOutput("abort_no_done", done_count - done0, 0);
            exp_q.delete();
        end else begin
            checkOutput("queue_drained", exp_q.size(), 0);
            checkOutput("done_pulses", done_count - done0, 1);
            if (ready_pct == 100) checkOutput("throughput_cycles", run_cycles, npix);
        end
    endtask

    // Start a 10x10 scan and hit it with reset between clock edges
    task automatic resetMidScan();
        int npix;
        waitIdle();
        pushModel(20, 29, 40, 49, npix);
        bus.start = 1'b1;
        bus.x0 = 9'd20; bus.x1 = 9'd29; bus.y0 = 8'd40; bus.y1 = 8'd49;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_valid", bus.out_valid, 0);
        checkOutput("rst_async_busy", bus.busy, 0);
        checkOutput("rst_async_done", bus.done, 0);
        checkOutput("rst_async_x", bus.out_x, 0);
        checkOutput("rst_async_y", bus.out_y, 0);
        checkOutput("rst_async_addr", bus.out_addr, 0);
        @(posedge clk); #1;
        checkOutput("rst_hold_busy", bus.busy, 0);
        rst = 1'b0;
        bus.out_ready = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        checkOutput("rst_no_done", bus.done, 0);
        checkOutput("rst_idle_valid", bus.out_valid, 0);
    endtask

    // Monitor: check accepted pixels and held pixels against the
    // scoreboard, and check the done pulse lands right after the last one
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pending_done = 1'b0;
            end else begin
                if (bus.done || pending_done) begin
                    checkOutput("done_pulse", bus.done, pending_done);
                    if (bus.done) done_count++;
                end
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_beat", 1, 0);
                    end else if (!bus.out_ready) begin
                        checkOutput("hold_addr", bus.out_addr, exp_q[0].addr);
                    end else begin
                        mon_e = exp_q.pop_front();
                        checkOutput("beat_addr", bus.out_addr, mon_e.addr);
                        checkOutput("beat_x_y_last", {bus.out_x, bus.out_y, bus.out_last},
                                    {mon_e.x, mon_e.y, mon_e.last});
                        checkOutput("beat_lut_y", bus.lut_y, mon_e.y);
                        accepted++;
                    end
                end
                pending_done = bus.out_valid && bus.out_ready && bus.out_last && !bus.abort;
            end
        end
    end

    // Watchdog so a stuck design still ends the run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed cases first, then randomized rectangles
    initial begin
        int rx0, rx1, ry0, ry1, rpct, rab;
        vectors = 0;
        miscompares = 0;
        accepted = 0;
        done_count = 0;
        pending_done = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.out_ready = 1'b0;
        bus.x0 = '0; bus.x1 = '0; bus.y0 = '0; bus.y1 = '0;
        #2;
        checkOutput("reset_valid", bus.out_valid, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_last", bus.out_last, 0);
        checkOutput("reset_x", bus.out_x, 0);
        checkOutput("reset_y", bus.out_y, 0);
        checkOutput("reset_lut_y", bus.lut_y, 0);
        checkOutput("reset_addr", bus.out_addr, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(5, 5, 7, 7, -1, 100, 1'b0);
        applyStimulus(3, 1, 1, 0, -1, 100, 1'b0);
        applyStimulus(318, 400, 238, 255, -1, 100, 1'b0);
        applyStimulus(0, 1, 0, 0, -1, -1, 1'b0);
        applyStimulus(0, 9, 0, 9, 4, 100, 1'b1);
        applyStimulus(2, 4, 3, 5, -1, 100, 1'b0);
        resetMidScan();
        applyStimulus(7, 2, 9, 6, -1, 60, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rx0 = int'($urandom_range(511));
            rx1 = rx0 + int'($urandom_range(12)) - 6;
            if (rx1 < 0) rx1 = 0;
            if (rx1 > 511) rx1 = 511;
            ry0 = int'($urandom_range(255));
            ry1 = ry0 + int'($urandom_range(12)) - 6;
            if (ry1 < 0) ry1 = 0;
            if (ry1 > 255) ry1 = 255;
            case ($urandom_range(2))
                0:       rpct = 100;
                1:       rpct = 70;
                default: rpct = 40;
            endcase
            rab = ($urandom_range(4) == 0) ? -2 : -1;
            applyStimulus(rx0, rx1, ry0, ry1, rab, rpct, $urandom_range(1) == 1);
        end

        waitIdle();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
